// File: rtl/cpu_bus_pkg.sv
// ============================================================================
// Module : cpu_bus_pkg
// Brief  : Shared encodings for the CPU-side memory bus masters: arbiter
//          state codes, port-owner codes, default abort limit and a helper
//          that sizes the abort counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_bus_pkg;

  // Arbiter state encoding
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // Owner of the memory port
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  // Cycles a transaction may wait in BUSY before it is aborted
  localparam int DEFAULT_TIMEOUT = 15;

  // Counter width able to hold values up to 'limit'; at least one bit
  function automatic int ctr_width(input int limit);
    if (limit < 2) begin
      return 1;
    end
    return $clog2(limit + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bus_timeout_ctr.sv
// ============================================================================
// Module : bus_timeout_ctr
// Brief  : Wait-cycle counter for a bus master. Counts while enabled, clears
//          on request, and flags the cycle in which the count of enabled
//          cycles reaches 'limit'. A limit of zero never expires.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bus_timeout_ctr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         expired
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins, otherwise advance while enabled
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + ONE;
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The current enabled cycle is the limit-th one when cnt_q == limit-1
  assign expired = enable && !clear && (limit != '0) && ((cnt_q + ONE) == limit);

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module : mem_port_arbiter
// Brief  : Shares one synchronous memory port between the instruction-fetch
//          requester (IF) and the load/store requester (D). Each transaction
//          runs IDLE (arbitrate, grant) -> BUSY (hold request until ack or
//          abort) -> RESP (one-cycle valid pulse to the owner).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  // Instruction fetch requester
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_err,
  // Data load/store requester
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_be,
  output logic              d_gnt,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              d_err,
  // Memory port
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int           CW    = ctr_width(TIMEOUT);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_owner_q, last_owner_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic              if_err_q, if_err_d;
  logic              d_valid_q, d_valid_d;
  logic              d_err_q, d_err_d;

  logic              arb_en;
  logic              gnt_data;
  logic              gnt_fetch;
  logic              ctr_clear;
  logic              ctr_enable;
  logic              expired;

  // Arbitration only in IDLE and never while reset is held, so grants stay
  // low during reset. D wins contention unless it owned the port last time.
  assign arb_en    = (state_q == IDLE) && !rst;
  assign gnt_data  = arb_en && d_req && (!if_req || (last_owner_q == OWN_IF));
  assign gnt_fetch = arb_en && if_req && !gnt_data;

  // Wait counter runs only in BUSY and restarts for every transaction
  assign ctr_clear  = (state_q != BUSY);
  assign ctr_enable = (state_q == BUSY);

  bus_timeout_ctr #(
    .W (CW)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (ctr_clear),
    .enable  (ctr_enable),
    .limit   (LIMIT),
    .expired (expired)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: grant leaves IDLE, ack or abort leaves BUSY, RESP lasts one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (gnt_data || gnt_fetch) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (mem_ack || expired) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs and datapath: capture the winner, hold it in BUSY, respond once
  always_comb begin
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    if_valid_d   = 1'b0;
    if_err_d     = 1'b0;
    d_valid_d    = 1'b0;
    d_err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_data) begin
          mem_req_d    = 1'b1;
          mem_we_d     = d_we;
          mem_addr_d   = d_addr;
          mem_wdata_d  = d_wdata;
          mem_be_d     = d_be;
          owner_d      = OWN_D;
          last_owner_d = OWN_D;
        end else if (gnt_fetch) begin
          // Fetches are always full-word reads
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = if_addr;
          mem_be_d     = 4'hF;
          owner_d      = OWN_IF;
          last_owner_d = OWN_IF;
        end
      end
      BUSY: begin
        // An ack in the abort cycle still completes the transaction normally
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (owner_q == OWN_D) begin
            d_rdata_d = mem_we_q ? '0 : mem_rdata;
            d_valid_d = 1'b1;
          end else begin
            if_rdata_d = mem_rdata;
            if_valid_d = 1'b1;
          end
        end else if (expired) begin
          mem_req_d = 1'b0;
          if (owner_q == OWN_D) begin
            d_rdata_d = '0;
            d_valid_d = 1'b1;
            d_err_d   = 1'b1;
          end else begin
            if_rdata_d = '0;
            if_valid_d = 1'b1;
            if_err_d   = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset hands last ownership to IF so D wins first
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= 4'h0;
      owner_q      <= OWN_IF;
      last_owner_q <= OWN_IF;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      if_valid_q   <= 1'b0;
      if_err_q     <= 1'b0;
      d_valid_q    <= 1'b0;
      d_err_q      <= 1'b0;
    end else begin
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      if_valid_q   <= if_valid_d;
      if_err_q     <= if_err_d;
      d_valid_q    <= d_valid_d;
      d_err_q      <= d_err_d;
    end
  end

  assign if_gnt    = gnt_fetch;
  assign d_gnt     = gnt_data;
  assign if_rdata  = if_rdata_q;
  assign if_valid  = if_valid_q;
  assign if_err    = if_err_q;
  assign d_rdata   = d_rdata_q;
  assign d_valid   = d_valid_q;
  assign d_err     = d_err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module : tb_mem_port_arbiter
// Brief  : Self-checking bench for mem_port_arbiter: a memory model answers
//          requests after a programmable latency, grants and responses are
//          checked against queues filled when stimulus is issued.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt;
  logic [DW-1:0] if_rdata;
  logic          if_valid;
  logic          if_err;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [3:0]    d_be = 4'h0;
  logic          d_gnt;
  logic [DW-1:0] d_rdata;
  logic          d_valid;
  logic          d_err;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_be;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  mem_port_arbiter #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rdata  (if_rdata),
    .if_valid  (if_valid),
    .if_err    (if_err),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_be      (d_be),
    .d_gnt     (d_gnt),
    .d_rdata   (d_rdata),
    .d_valid   (d_valid),
    .d_err     (d_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          own;   // 1 = D, 0 = IF
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  int            total = 0;
  int            bad = 0;
  exp_t          exp_q[$];
  logic          gnt_q[$];
  logic [DW-1:0] mdata_q[$];
  int            ack_lat = 0;   // ack in this BUSY cycle (1-based), 0 = never
  logic          stray = 1'b0;
  int            busy_cnt = 0;
  int            cyc = 0;
  int            valid_seen = 0;
  exp_t          mon_e;
  logic          mon_g;

  always @(posedge clk) cyc++;

  // Memory model: drives ack/rdata shortly after each edge
  always @(posedge clk) begin
    #2;
    if (mem_req) begin
      busy_cnt++;
      if (ack_lat != 0 && busy_cnt == ack_lat) begin
        mem_ack   = 1'b1;
        mem_rdata = (mdata_q.size() != 0) ? mdata_q.pop_front() : 32'hBAD0BAD0;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 32'h0BADF00D;
      end
    end else begin
      busy_cnt  = 0;
      mem_ack   = stray;
      mem_rdata = 32'hCAFEF00D;
      stray     = 1'b0;
    end
  end

  // Scoreboard monitor: grants and responses against queued expectations
  always @(negedge clk) begin
    if (!rst) begin
      if (if_gnt || d_gnt) begin
        total++;
        if (gnt_q.size() == 0 || (if_gnt && d_gnt)) begin
          bad++;
          $display("FAIL gnt_unexpected: if_gnt=%0b d_gnt=%0b pending=%0d, required one queued grant",
                   if_gnt, d_gnt, gnt_q.size());
        end else begin
          mon_g = gnt_q.pop_front();
          if (d_gnt !== mon_g) begin
            bad++;
            $display("FAIL gnt_order: got d_gnt=%0b if_gnt=%0b, required d_gnt=%0b", d_gnt, if_gnt, mon_g);
          end
        end
      end
      if (if_valid || d_valid) begin
        valid_seen++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL valid_unexpected: if_valid=%0b d_valid=%0b with no pending transaction", if_valid, d_valid);
        end else begin
          mon_e = exp_q.pop_front();
          if ((if_valid && d_valid) || (d_valid !== mon_e.own) ||
              ((d_valid ? d_rdata : if_rdata) !== mon_e.rdata) ||
              ((d_valid ? d_err : if_err) !== mon_e.err) ||
              ((d_valid ? if_err : d_err) !== 1'b0)) begin
            bad++;
            $display("FAIL response: got if_v=%0b d_v=%0b if_rd=%h d_rd=%h if_err=%0b d_err=%0b, required own=%0b rdata=%h err=%0b",
                     if_valid, d_valid, if_rdata, d_rdata, if_err, d_err, mon_e.own, mon_e.rdata, mon_e.err);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req  = 1'b0;
    if_addr = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    d_be    = 4'h0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (exp_q.size() != 0 || gnt_q.size() != 0); i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    @(negedge clk);
    total++;
    if ({if_gnt, if_rdata, if_valid, if_err, d_gnt, d_rdata, d_valid, d_err,
         mem_req, mem_we, mem_addr, mem_wdata, mem_be} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: mem_req=%0b mem_addr=%h if_rdata=%h d_rdata=%h, required all zero",
               mem_req, mem_addr, if_rdata, d_rdata);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    ack_lat = 2;
    mdata_q.push_back(32'hE3A01005);
    gnt_q.push_back(1'b0);
    exp_q.push_back('{1'b0, 32'hE3A01005, 1'b0});
    if_req  = 1'b1;
    if_addr = 32'h100;
    @(negedge clk);
    total++;
    if (if_gnt !== 1'b1 || mem_req !== 1'b0) begin
      bad++;
      $display("FAIL fetch_gnt: if_gnt=%0b mem_req=%0b, required 1/0", if_gnt, mem_req);
    end
    tick();
    if_req  = 1'b0;
    if_addr = 32'hFFFF_FFF0;
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      total++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0 || mem_be !== 4'hF || if_valid !== 1'b0) begin
        bad++;
        $display("FAIL fetch_busy%0d: req=%0b addr=%h we=%0b be=%h valid=%0b, required 1/00000100/0/f/0",
                 i, mem_req, mem_addr, mem_we, mem_be, if_valid);
      end
      tick();
    end
    @(negedge clk);
    total++;
    if (if_valid !== 1'b1 || if_rdata !== 32'hE3A01005 || if_err !== 1'b0 || mem_req !== 1'b0) begin
      bad++;
      $display("FAIL fetch_resp: valid=%0b rdata=%h err=%0b req=%0b, required 1/e3a01005/0/0",
               if_valid, if_rdata, if_err, mem_req);
    end
    tick();
    @(negedge clk);
    total++;
    if (if_valid !== 1'b0) begin
      bad++;
      $display("FAIL fetch_valid_pulse: if_valid=%0b, required 0", if_valid);
    end
    tick();
  endtask

  // Both requesters high: D first, then IF in the next IDLE
  task automatic contend(input logic [DW-1:0] da, input logic [DW-1:0] ia, input string nm);
    bit got;
    ack_lat = 1;
    mdata_q.push_back(da);
    mdata_q.push_back(ia);
    gnt_q.push_back(1'b1);
    gnt_q.push_back(1'b0);
    exp_q.push_back('{1'b1, da, 1'b0});
    exp_q.push_back('{1'b0, ia, 1'b0});
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 32'h200;
    d_be    = 4'hF;
    if_req  = 1'b1;
    if_addr = 32'h104;
    @(negedge clk);
    total++;
    if (d_gnt !== 1'b1 || if_gnt !== 1'b0) begin
      bad++;
      $display("FAIL %s_first: d_gnt=%0b if_gnt=%0b, required 1/0", nm, d_gnt, if_gnt);
    end
    tick();
    d_req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (if_gnt === 1'b1) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL %s_if_gnt: if_gnt=0 after 10 cycles, required 1", nm);
    end
    tick();
    if_req = 1'b0;
    drain();
    @(negedge clk);
    total++;
    if (d_rdata !== da || if_rdata !== ia || exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_rdata: d_rdata=%h if_rdata=%h pending=%0d, required %h/%h/0",
               nm, d_rdata, if_rdata, exp_q.size(), da, ia);
    end
    tick();
  endtask

  task automatic test_contention();
    apply_reset();
    contend(32'h1111_0000, 32'h2222_0000, "contention");
  endtask

  task automatic test_store();
    ack_lat = 3;
    mdata_q.push_back(32'h5555_5555);
    gnt_q.push_back(1'b1);
    exp_q.push_back('{1'b1, 32'h0, 1'b0});
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h40;
    d_wdata = 32'hDEADBEEF;
    d_be    = 4'b0011;
    @(negedge clk);
    total++;
    if (d_gnt !== 1'b1) begin
      bad++;
      $display("FAIL store_gnt: d_gnt=%0b, required 1", d_gnt);
    end
    tick();
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = 32'h0;
    d_wdata = 32'h0;
    d_be    = 4'hF;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      total++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h40 ||
          mem_wdata !== 32'hDEADBEEF || mem_be !== 4'b0011) begin
        bad++;
        $display("FAIL store_hold%0d: req=%0b we=%0b addr=%h wdata=%h be=%h, required 1/1/00000040/deadbeef/3",
                 i, mem_req, mem_we, mem_addr, mem_wdata, mem_be);
      end
      tick();
    end
    @(negedge clk);
    total++;
    if (d_valid !== 1'b1 || d_rdata !== 32'h0 || d_err !== 1'b0) begin
      bad++;
      $display("FAIL store_resp: valid=%0b rdata=%h err=%0b, required 1/00000000/0", d_valid, d_rdata, d_err);
    end
    tick();
  endtask

  task automatic test_timeout();
    int n;
    ack_lat = 0;
    gnt_q.push_back(1'b0);
    exp_q.push_back('{1'b0, 32'h0, 1'b1});
    if_req  = 1'b1;
    if_addr = 32'h300;
    @(negedge clk);
    total++;
    if (if_gnt !== 1'b1) begin
      bad++;
      $display("FAIL timeout_gnt: if_gnt=%0b, required 1", if_gnt);
    end
    tick();
    if_req = 1'b0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (mem_req !== 1'b1) break;
      n++;
      tick();
    end
    total++;
    if (n != TO) begin
      bad++;
      $display("FAIL timeout_req_cycles: mem_req high %0d cycles, required %0d", n, TO);
    end
    total++;
    if (if_valid !== 1'b1 || if_err !== 1'b1 || if_rdata !== 32'h0) begin
      bad++;
      $display("FAIL timeout_resp: valid=%0b err=%0b rdata=%h, required 1/1/00000000", if_valid, if_err, if_rdata);
    end
    tick();
    @(negedge clk);
    total++;
    if (if_valid !== 1'b0 || if_err !== 1'b0 || mem_req !== 1'b0) begin
      bad++;
      $display("FAIL timeout_idle: valid=%0b err=%0b req=%0b, required 0/0/0", if_valid, if_err, mem_req);
    end
    tick();
  endtask

  task automatic test_reset_mid_busy();
    int v0;
    ack_lat = 0;
    gnt_q.push_back(1'b1);
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h80;
    d_be   = 4'hF;
    @(negedge clk);
    total++;
    if (d_gnt !== 1'b1) begin
      bad++;
      $display("FAIL rstbusy_gnt: d_gnt=%0b, required 1", d_gnt);
    end
    tick();
    d_req = 1'b0;
    @(negedge clk);
    total++;
    if (mem_req !== 1'b1) begin
      bad++;
      $display("FAIL rstbusy_req: mem_req=%0b, required 1", mem_req);
    end
    tick();
    v0  = valid_seen;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({if_gnt, if_rdata, if_valid, if_err, d_gnt, d_rdata, d_valid, d_err,
         mem_req, mem_we, mem_addr, mem_wdata, mem_be} !== '0) begin
      bad++;
      $display("FAIL rstbusy_outputs: mem_req=%0b mem_addr=%h d_valid=%0b d_err=%0b, required all zero",
               mem_req, mem_addr, d_valid, d_err);
    end
    repeat (4) begin
      tick();
      @(negedge clk);
    end
    total++;
    if (valid_seen != v0) begin
      bad++;
      $display("FAIL rstbusy_no_valid: %0d responses after reset, required 0", valid_seen - v0);
    end
    tick();
    contend(32'h3333_0000, 32'h4444_0000, "rstbusy_contention");
  endtask

  task automatic test_back_to_back();
    int gcyc[4];
    int ng;
    int v0;
    ack_lat = 1;
    for (int i = 0; i < 4; i++) begin
      mdata_q.push_back(32'hA000_0000 + i);
      gnt_q.push_back((i % 2) == 0);
      exp_q.push_back('{((i % 2) == 0), 32'hA000_0000 + i, 1'b0});
    end
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 32'h500;
    d_be    = 4'hF;
    if_req  = 1'b1;
    if_addr = 32'h600;
    ng = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if_gnt === 1'b1 || d_gnt === 1'b1) begin
        gcyc[ng] = cyc;
        ng++;
      end
      if (ng == 4) break;
      tick();
    end
    tick();
    d_req  = 1'b0;
    if_req = 1'b0;
    drain();
    total++;
    if (ng != 4 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL b2b_count: %0d grants pending=%0d, required 4/0", ng, exp_q.size());
    end else begin
      for (int i = 1; i < 4; i++) begin
        total++;
        if (gcyc[i] - gcyc[i-1] != 3) begin
          bad++;
          $display("FAIL b2b_spacing%0d: %0d cycles between grants, required 3", i, gcyc[i] - gcyc[i-1]);
        end
      end
    end
    v0    = valid_seen;
    stray = 1'b1;
    repeat (5) begin
      @(negedge clk);
      tick();
    end
    @(negedge clk);
    total++;
    if (valid_seen != v0 || mem_req !== 1'b0) begin
      bad++;
      $display("FAIL stray_ack: %0d responses mem_req=%0b, required 0/0", valid_seen - v0, mem_req);
    end
    tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fetch();
    test_contention();
    test_store();
    test_timeout();
    test_reset_mid_busy();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one synchronous memory port between two requesters: instruction fetch (IF) and data load/store (D).
- Sequences each transaction: arbitration, address/data hold until the memory acknowledges, then a one-cycle response pulse.
- if_valid drives the control FSM's instruction-valid input (W_IR_valid); the D side serves LDR/STR.
- Sits between the control FSM/datapath and the memory interface.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 15, max BUSY cycles without mem_ack before abort; 0 disables timeout

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
if_req  in  1  fetch request, level
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  one-cycle pulse: fetch request captured
if_rdata  out  DATA_W  fetched instruction, registered
if_valid  out  1  one-cycle pulse: if_rdata valid / fetch done
if_err  out  1  one-cycle pulse with if_valid on timeout
d_req  in  1  data request, level
d_we  in  1  1=store, 0=load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_be  in  4  byte enables
d_gnt  out  1  one-cycle pulse: data request captured
d_rdata  out  DATA_W  load data, registered
d_valid  out  1  one-cycle pulse: data transaction done
d_err  out  1  one-cycle pulse with d_valid on timeout
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_be  out  4  memory byte enables
mem_ack  in  1  memory completion, one cycle
mem_rdata  in  DATA_W  read data, valid with mem_ack

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock port is clk, reset port is rst.
- Reset values: every output is 0. State=IDLE, owner=IF, last_owner=IF (so D wins the first contention), timeout counter=0.
- States: IDLE, BUSY, RESP.
- IDLE arbitration:
  - D wins if d_req && (!if_req || last_owner==IF).
  - Otherwise IF wins if if_req.
  - Otherwise stay in IDLE.
  - Winner: its gnt pulses this cycle. Its addr/we/wdata/be are registered into the mem_* registers, owner and last_owner are set, next state is BUSY.
  - IF grants force mem_we=0 and mem_be=4'hF.
- BUSY:
  - mem_req=1; mem_we/addr/wdata/be held stable.
  - Counter increments each cycle.
  - On mem_ack: capture mem_rdata into the owner's rdata register (0 for stores), drop mem_req at the next edge, go to RESP.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT with no ack: drop mem_req, set the owner's rdata=0, flag err, go to RESP.
- RESP:
  - Owner's valid=1 for exactly one cycle; err=1 with it if aborted.
  - Counter cleared; next state IDLE.
  - The non-owner's rdata register is unchanged.
- Latency: gnt at cycle T, mem_req first high at T+1, valid at ack_cycle+1. Minimum 3 cycles per transaction, no overlap.
- Requesters may drop req after gnt; input changes after gnt are ignored. A req dropped before gnt is never served.
- Starvation: under continuous requests from both sides, grants alternate D, IF, D, IF.
- Boundary cases:
  - mem_ack in IDLE or RESP is ignored.
  - mem_ack in the same cycle the timeout is reached counts as success, not error.
  - rst mid-BUSY: mem_req=0 at the next edge, no valid/err is emitted for the aborted transaction, last_owner=IF.

Decomposition:
- Shared package cpu_bus_pkg: state encoding localparams (IDLE=2'd0, BUSY=2'd1, RESP=2'd2), owner encoding (OWN_IF=1'b0, OWN_D=1'b1), default TIMEOUT.
- One natural sub-module: bus_timeout_ctr (clear/enable/limit inputs, expired output), reusable by future bus masters.

Test Plan:
- Reset, then if_req=1, if_addr=0x100, ack after 2 BUSY cycles with rdata=0xE3A01005 -> if_gnt at T, mem_req T+1..T+2, if_valid at T+3 with if_rdata=0xE3A01005, if_err=0.
- if_req and d_req both high from reset, d_we=0, d_addr=0x200 -> D granted first; IF granted in the next IDLE. d_rdata = mem_rdata of the first ack, if_rdata = mem_rdata of the second.
- Store d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF, d_be=4'b0011 -> mem_we=1, mem_wdata/mem_be held stable all of BUSY, d_valid pulse, d_rdata=0.
- TIMEOUT=4, no mem_ack on a fetch -> mem_req high exactly 4 cycles; if_valid and if_err pulse together; if_rdata=0; return to IDLE.
- rst asserted on the 2nd BUSY cycle of a D load -> all outputs 0 next edge, no d_valid. A subsequent contending request pair grants D first.
- Both requesters held high for 4 transactions with ack in the first BUSY cycle -> grant order D, IF, D, IF, one transaction per 3 cycles. A stray mem_ack during IDLE produces no valid.
